uart_fifo: RTL and testbench

UART_FIFO -- requirements
Module: uart_fifo

---
 rtl/uart_fifo.sv | 320 ++++++++++++++++++++++++++++++++
 tb/tb_uart_fifo.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo.sv
// uart_fifo: UART transmitter and receiver, each buffered by a FIFO.
//
// Parameters
//   CLKDIV : clk cycles per serial bit (>= 4)
//   DEPTH  : entries per FIFO (power of two, >= 2)
//   DBITS  : data bits per frame (5..8)
//   PARITY : 0 = none, 1 = odd, 2 = even
//
// Ports
//   clk, rst         : clock, synchronous active-high reset
//   txd, txstart     : byte to send and push request; txwait = TX FIFO full
//   rxq, rxstart     : RX FIFO head and pop request; rxwait = RX FIFO empty
//   rx, tx           : serial input (asynchronous) and serial output
//   txcount, rxcount : FIFO occupancies (0..DEPTH)
//   clrerr           : clears the sticky ferr / perr / ovr flags
module uart_fifo #(
  parameter int CLKDIV = 5208,
  parameter int DEPTH  = 16,
  parameter int DBITS  = 8,
  parameter int PARITY = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               txd,
  input  logic                     txstart,
  output logic                     txwait,
  output logic [7:0]               rxq,
  input  logic                     rxstart,
  output logic                     rxwait,
  input  logic                     rx,
  output logic                     tx,
  output logic [$clog2(DEPTH):0]   txcount,
  output logic [$clog2(DEPTH):0]   rxcount,
  input  logic                     clrerr,
  output logic                     ferr,
  output logic                     perr,
  output logic                     ovr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = $clog2(CLKDIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLKDIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLKDIV / 2 - 1);
  localparam logic [2:0]    LAST_BIT = 3'(DBITS - 1);

  // Parity bit that accompanies data d on the line.
  function automatic logic par_bit(input logic [DBITS-1:0] d);
    return (PARITY == 1) ? ~^d : ^d;
  endfunction

  // ---------------------------------------------------------------- TX FIFO
  logic [DBITS-1:0] tx_mem [DEPTH];
  logic [AW-1:0]    tx_wp, tx_rp;
  logic [DBITS-1:0] tx_head;
  logic             tx_push, tx_pop;

  assign txwait  = (txcount == CW'(DEPTH));
  assign tx_push = txstart & ~txwait & ~rst;
  assign tx_head = tx_mem[tx_rp];

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wp   <= '0;
      tx_rp   <= '0;
      txcount <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + AW'(1);
      if (tx_pop)  tx_rp <= tx_rp + AW'(1);
      if (tx_push & ~tx_pop)      txcount <= txcount + CW'(1);
      else if (~tx_push & tx_pop) txcount <= txcount - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp] <= txd[DBITS-1:0];
  end

  // ---------------------------------------------------------------- TX FSM
  typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_PAR, T_STOP} tx_state_t;

  tx_state_t        t_state, t_state_d;
  logic [DW-1:0]    t_cnt, t_cnt_d;
  logic [2:0]       t_bit, t_bit_d;
  logic [DBITS-1:0] t_sh, t_sh_d;
  logic             t_par, t_par_d;
  logic             t_end;

  always_ff @(posedge clk) begin
    if (rst) begin
      t_state <= T_IDLE;
      t_cnt   <= '0;
      t_bit   <= '0;
      t_sh    <= '0;
      t_par   <= 1'b0;
    end else begin
      t_state <= t_state_d;
      t_cnt   <= t_cnt_d;
      t_bit   <= t_bit_d;
      t_sh    <= t_sh_d;
      t_par   <= t_par_d;
    end
  end

  always_comb begin
    t_state_d = t_state;
    t_cnt_d   = t_cnt + DW'(1);
    t_bit_d   = t_bit;
    t_sh_d    = t_sh;
    t_par_d   = t_par;
    tx_pop    = 1'b0;
    t_end     = (t_cnt == DIV_LAST);
    case (t_state)
      T_IDLE: begin
        t_cnt_d = '0;
        if (txcount != '0) begin
          tx_pop    = 1'b1;
          t_sh_d    = tx_head;
          t_par_d   = par_bit(tx_head);
          t_state_d = T_START;
        end
      end
      T_START: begin
        if (t_end) begin
          t_cnt_d   = '0;
          t_bit_d   = '0;
          t_state_d = T_DATA;
        end
      end
      T_DATA: begin
        if (t_end) begin
          t_cnt_d = '0;
          t_sh_d  = t_sh >> 1;
          if (t_bit == LAST_BIT) t_state_d = (PARITY != 0) ? T_PAR : T_STOP;
          else                   t_bit_d   = t_bit + 3'd1;
        end
      end
      T_PAR: begin
        if (t_end) begin
          t_cnt_d   = '0;
          t_state_d = T_STOP;
        end
      end
      T_STOP: begin
        if (t_end) begin
          t_cnt_d = '0;
          // Chain straight into the next frame so queued bytes leave gap-free.
          if (txcount != '0) begin
            tx_pop    = 1'b1;
            t_sh_d    = tx_head;
            t_par_d   = par_bit(tx_head);
            t_state_d = T_START;
          end else begin
            t_state_d = T_IDLE;
          end
        end
      end
      default: t_state_d = T_IDLE;
    endcase
  end

  always_comb begin
    case (t_state)
      T_START: tx = 1'b0;
      T_DATA:  tx = t_sh[0];
      T_PAR:   tx = t_par;
      default: tx = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------- RX sync
  logic rx_s1, rx_s2, rx_s3, rx_fall;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_s3 <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
    end
  end

  assign rx_fall = rx_s3 & ~rx_s2;

  // ---------------------------------------------------------------- RX FSM
  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PAR, R_STOP} rx_state_t;

  rx_state_t        r_state, r_state_d;
  logic [DW-1:0]    r_cnt, r_cnt_d;
  logic [2:0]       r_bit, r_bit_d;
  logic [DBITS-1:0] r_sh, r_sh_d;
  logic             r_pbad, r_pbad_d;
  logic             r_good, r_good_d;
  logic             ferr_set, perr_set, ovr_set;
  logic             r_end;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= R_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_sh    <= '0;
      r_pbad  <= 1'b0;
      r_good  <= 1'b0;
    end else begin
      r_state <= r_state_d;
      r_cnt   <= r_cnt_d;
      r_bit   <= r_bit_d;
      r_sh    <= r_sh_d;
      r_pbad  <= r_pbad_d;
      r_good  <= r_good_d;
    end
  end

  always_comb begin
    r_state_d = r_state;
    r_cnt_d   = r_cnt + DW'(1);
    r_bit_d   = r_bit;
    r_sh_d    = r_sh;
    r_pbad_d  = r_pbad;
    r_good_d  = 1'b0;
    ferr_set  = 1'b0;
    perr_set  = 1'b0;
    r_end     = (r_cnt == DIV_LAST);
    case (r_state)
      R_IDLE: begin
        r_cnt_d = '0;
        if (rx_fall) begin
          r_pbad_d  = 1'b0;
          r_state_d = R_START;
        end
      end
      R_START: begin
        if (r_cnt == DIV_HALF) begin
          r_cnt_d = '0;
          if (rx_s2) begin
            r_state_d = R_IDLE;
          end else begin
            r_bit_d   = '0;
            r_state_d = R_DATA;
          end
        end
      end
      R_DATA: begin
        if (r_end) begin
          r_cnt_d = '0;
          r_sh_d  = {rx_s2, r_sh[DBITS-1:1]};
          if (r_bit == LAST_BIT) r_state_d = (PARITY != 0) ? R_PAR : R_STOP;
          else                   r_bit_d   = r_bit + 3'd1;
        end
      end
      R_PAR: begin
        if (r_end) begin
          r_cnt_d = '0;
          if (rx_s2 != par_bit(r_sh)) begin
            r_pbad_d = 1'b1;
            perr_set = 1'b1;
          end
          r_state_d = R_STOP;
        end
      end
      R_STOP: begin
        if (r_end) begin
          r_cnt_d   = '0;
          r_state_d = R_IDLE;
          if (!rx_s2)       ferr_set = 1'b1;
          else if (!r_pbad) r_good_d = 1'b1;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- RX FIFO
  logic [DBITS-1:0] rx_mem [DEPTH];
  logic [AW-1:0]    rx_wp, rx_rp;
  logic             rx_push, rx_pop, rx_full;

  assign rxwait  = (rxcount == '0);
  assign rx_full = (rxcount == CW'(DEPTH));
  assign rx_pop  = rxstart & ~rxwait & ~rst;
  // A full FIFO still takes the byte when the head leaves in the same cycle.
  assign rx_push = r_good & (~rx_full | rx_pop) & ~rst;
  assign ovr_set = r_good & rx_full & ~rx_pop;
  assign rxq     = 8'(rx_mem[rx_rp]);

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wp   <= '0;
      rx_rp   <= '0;
      rxcount <= '0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + AW'(1);
      if (rx_pop)  rx_rp <= rx_rp + AW'(1);
      if (rx_push & ~rx_pop)      rxcount <= rxcount + CW'(1);
      else if (~rx_push & rx_pop) rxcount <= rxcount - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wp] <= r_sh;
  end

  // ---------------------------------------------------------------- Flags
  always_ff @(posedge clk) begin
    if (rst) begin
      ferr <= 1'b0;
      perr <= 1'b0;
      ovr  <= 1'b0;
    end else begin
      ferr <= (ferr & ~clrerr) | ferr_set;
      perr <= (perr & ~clrerr) | perr_set;
      ovr  <= (ovr  & ~clrerr) | ovr_set;
    end
  end

endmodule

// File: tb/tb_uart_fifo.sv
module tb_uart_fifo;
  localparam int CLKDIV = 4;
  localparam int DEPTH  = 4;
  localparam int CW     = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic [7:0]    txd0, rxq0;
  logic          txstart0, txwait0, rxstart0, rxwait0, rx0, tx0, clrerr0, ferr0, perr0, ovr0;
  logic [CW-1:0] txcount0, rxcount0;

  logic [7:0]    txd2, rxq2;
  logic          txstart2, txwait2, rxstart2, rxwait2, rx2, tx2, clrerr2, ferr2, perr2, ovr2;
  logic [CW-1:0] txcount2, rxcount2;
  logic          loop2, rxdrv2;

  assign rx2 = loop2 ? tx2 : rxdrv2;

  uart_fifo #(.CLKDIV(CLKDIV), .DEPTH(DEPTH), .DBITS(8), .PARITY(0)) dut0 (
    .clk(clk), .rst(rst), .txd(txd0), .txstart(txstart0), .txwait(txwait0),
    .rxq(rxq0), .rxstart(rxstart0), .rxwait(rxwait0), .rx(rx0), .tx(tx0),
    .txcount(txcount0), .rxcount(rxcount0), .clrerr(clrerr0),
    .ferr(ferr0), .perr(perr0), .ovr(ovr0));

  uart_fifo #(.CLKDIV(CLKDIV), .DEPTH(DEPTH), .DBITS(8), .PARITY(2)) dut2 (
    .clk(clk), .rst(rst), .txd(txd2), .txstart(txstart2), .txwait(txwait2),
    .rxq(rxq2), .rxstart(rxstart2), .rxwait(rxwait2), .rx(rx2), .tx(tx2),
    .txcount(txcount2), .rxcount(rxcount2), .clrerr(clrerr2),
    .ferr(ferr2), .perr(perr2), .ovr(ovr2));

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_rx(input int which, input logic v);
    if (which == 0) rx0 = v;
    else            rxdrv2 = v;
  endtask

  task automatic send_frame(input int which, input logic [7:0] d, input logic has_par,
                            input logic pbit, input logic stopb);
    drive_rx(which, 1'b0);
    repeat (CLKDIV) tick();
    for (int i = 0; i < 8; i++) begin
      drive_rx(which, d[i]);
      repeat (CLKDIV) tick();
    end
    if (has_par) begin
      drive_rx(which, pbit);
      repeat (CLKDIV) tick();
    end
    drive_rx(which, stopb);
    repeat (CLKDIV) tick();
    drive_rx(which, 1'b1);
    repeat (8) tick();
  endtask

  // TX line scoreboard: bytes expected on dut0.tx, checked by the decoder below.
  logic [7:0] exp_tx_q[$];
  logic [7:0] exp_rx_q[$];
  int         starts[$];
  logic       mon_en;

  initial begin
    logic [7:0] mb;
    logic       mstop;
    int         mst;
    forever begin
      @(negedge clk);
      if (mon_en && !rst && tx0 === 1'b0) begin
        mst = cyc;
        starts.push_back(mst);
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CLKDIV) @(negedge clk);
          mb[i] = tx0;
        end
        repeat (CLKDIV) @(negedge clk);
        mstop = tx0;
        if (exp_tx_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL tx_unexpected_frame: got 0x%0h, expected no frame", mb);
        end else begin
          chk("tx_frame_data", mb, exp_tx_q.pop_front());
        end
        chk("tx_stop_bit", mstop, 1);
      end
    end
  end

  typedef struct {
    logic [7:0]    txd;
    logic          exp_wait;
    logic [CW-1:0] exp_cnt;
  } txvec_t;

  typedef struct {
    logic [7:0]    data;
    logic          accept;
    logic [CW-1:0] exp_cnt;
    logic          exp_ovr;
  } rxvec_t;

  txvec_t tv [6];
  rxvec_t rv [5];

  initial begin
    logic [7:0] pat;
    logic       expb;
    int         n0, w, zeros;

    tv[0] = '{8'h01, 1'b0, 3'd0};
    tv[1] = '{8'h02, 1'b0, 3'd1};
    tv[2] = '{8'h03, 1'b0, 3'd1};
    tv[3] = '{8'h04, 1'b0, 3'd2};
    tv[4] = '{8'h05, 1'b0, 3'd3};
    tv[5] = '{8'h06, 1'b1, 3'd4};

    rv[0] = '{8'h10, 1'b1, 3'd1, 1'b0};
    rv[1] = '{8'h11, 1'b1, 3'd2, 1'b0};
    rv[2] = '{8'h12, 1'b1, 3'd3, 1'b0};
    rv[3] = '{8'h13, 1'b1, 3'd4, 1'b0};
    rv[4] = '{8'h14, 1'b0, 3'd4, 1'b1};

    rst = 1'b1; mon_en = 1'b0;
    txd0 = '0; txstart0 = 0; rxstart0 = 0; rx0 = 1; clrerr0 = 0;
    txd2 = '0; txstart2 = 0; rxstart2 = 0; rxdrv2 = 1; clrerr2 = 0; loop2 = 1;
    repeat (3) tick();

    // Reset state
    chk("rst_tx", tx0, 1);
    chk("rst_txwait", txwait0, 0);
    chk("rst_rxwait", rxwait0, 1);
    chk("rst_txcount", txcount0, 0);
    chk("rst_rxcount", rxcount0, 0);
    chk("rst_ferr", ferr0, 0);
    chk("rst_perr", perr0, 0);
    chk("rst_ovr", ovr0, 0);
    chk("rst_tx2", tx2, 1);
    rst = 1'b0; mon_en = 1'b1;
    tick();

    // Single 0x55 frame, cycle-exact waveform
    pat = 8'h55;
    txd0 = pat; txstart0 = 1; exp_tx_q.push_back(pat);
    tick();
    txstart0 = 0;
    for (int c = 1; c <= 45; c++) begin
      if (c < 2)        expb = 1'b1;
      else if (c < 6)   expb = 1'b0;
      else if (c < 38)  expb = pat[(c - 6) / 4];
      else              expb = 1'b1;
      chk($sformatf("tx55_c%0d", c), tx0, expb);
      tick();
    end

    // Six pushes into a depth-4 FIFO while the serializer drains one
    n0 = starts.size();
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("txq_wait_%0d", i), txwait0, tv[i].exp_wait);
      chk($sformatf("txq_cnt_%0d", i), txcount0, tv[i].exp_cnt);
      txd0 = tv[i].txd; txstart0 = 1;
      if (!tv[i].exp_wait) exp_tx_q.push_back(tv[i].txd);
      tick();
    end
    txstart0 = 0;
    chk("txq_cnt_after", txcount0, 4);
    repeat (230) tick();
    chk("txq_frames", starts.size() - n0, 5);
    if (starts.size() >= n0 + 5)
      for (int k = 1; k < 5; k++)
        chk($sformatf("txq_gap_%0d", k), starts[n0 + k] - starts[n0 + k - 1], 40);
    chk("txq_sb_drained", exp_tx_q.size(), 0);

    // Loopback with even parity
    txd2 = 8'hA3; txstart2 = 1;
    tick();
    txstart2 = 0;
    w = 0;
    while (rxwait2 && w < 200) begin tick(); w++; end
    chk("lb_rxwait_fall", rxwait2, 0);
    chk("lb_rxq", rxq2, 8'hA3);
    chk("lb_perr", perr2, 0);
    chk("lb_ferr", ferr2, 0);
    chk("lb_rxcount", rxcount2, 1);
    rxstart2 = 1; tick(); rxstart2 = 0;
    chk("lb_rxwait_pop", rxwait2, 1);
    chk("lb_rxcount_pop", rxcount2, 0);

    // Parity error and a correctly-parity frame driven by the bench
    loop2 = 0;
    send_frame(2, 8'h3C, 1'b1, 1'b1, 1'b1);
    chk("par_perr", perr2, 1);
    chk("par_rxwait", rxwait2, 1);
    chk("par_ferr", ferr2, 0);
    clrerr2 = 1; tick(); clrerr2 = 0;
    chk("par_clr", perr2, 0);
    send_frame(2, 8'h07, 1'b1, 1'b1, 1'b1);
    chk("par_good_rxwait", rxwait2, 0);
    chk("par_good_rxq", rxq2, 8'h07);
    chk("par_good_perr", perr2, 0);

    // Framing error
    send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b0);
    chk("fe_ferr", ferr0, 1);
    chk("fe_rxwait", rxwait0, 1);
    chk("fe_rxcount", rxcount0, 0);
    chk("fe_perr", perr0, 0);
    clrerr0 = 1; tick(); clrerr0 = 0;
    chk("fe_clr", ferr0, 0);

    // Overrun: five frames into a depth-4 RX FIFO
    for (int i = 0; i < 5; i++) begin
      send_frame(0, rv[i].data, 1'b0, 1'b0, 1'b1);
      if (rv[i].accept) exp_rx_q.push_back(rv[i].data);
      chk($sformatf("ovr_cnt_%0d", i), rxcount0, rv[i].exp_cnt);
      chk($sformatf("ovr_flag_%0d", i), ovr0, rv[i].exp_ovr);
      chk($sformatf("ovr_rxwait_%0d", i), rxwait0, 0);
    end
    while (exp_rx_q.size() > 0) begin
      chk("ovr_pop_data", rxq0, exp_rx_q.pop_front());
      rxstart0 = 1; tick(); rxstart0 = 0;
    end
    chk("ovr_empty", rxwait0, 1);
    chk("ovr_cnt_empty", rxcount0, 0);

    // Reset in the middle of frame 0xFF with two bytes queued
    mon_en = 0;
    txd0 = 8'hFF; txstart0 = 1; tick();
    txd0 = 8'h11; tick();
    txd0 = 8'h22; tick();
    txstart0 = 0;
    chk("abort_cnt_before", txcount0, 2);
    repeat (17) tick();
    rst = 1; txstart0 = 1; txd0 = 8'h77; rxstart0 = 1;
    tick();
    chk("abort_tx", tx0, 1);
    chk("abort_txcount", txcount0, 0);
    chk("abort_rxwait", rxwait0, 1);
    rst = 0; txstart0 = 0; rxstart0 = 0;
    zeros = 0;
    for (int i = 0; i < 80; i++) begin
      if (tx0 !== 1'b1) zeros++;
      tick();
    end
    chk("abort_no_frame", zeros, 0);
    chk("abort_txcount_after", txcount0, 0);

    // Reset while a zero data bit is on the line
    txd0 = 8'h00; txstart0 = 1; tick(); txstart0 = 0;
    repeat (12) tick();
    chk("abort0_tx_low", tx0, 0);
    rst = 1; tick(); rst = 0;
    chk("abort0_tx_high", tx0, 1);

    // Normal operation after reset
    mon_en = 1;
    tick();
    txd0 = 8'hC3; txstart0 = 1; exp_tx_q.push_back(8'hC3);
    tick(); txstart0 = 0;
    repeat (60) tick();
    chk("tx_sb_empty", exp_tx_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "simulation timeout");
  end

endmodule
